mio_responder: RTL and testbench

- Memory/IO-side responder for the multi-cycle CPU's memory bus. Serves the controller's MemRead/MemWrite requests from a word-addressed internal RAM and a small MMIO register file.
- Generates mio_ready, which the controller waits on in instruction fetch and uses to time data accesses.
- RAM accesses take a configurable number of wait cycles. MMIO accesses complete with the minimum latency.

---
 rtl/mio_pkg.sv | 49 ++++
 rtl/mio_ram.sv | 27 ++
 rtl/mio_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mio_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// mio_pkg: definitions shared by the memory/IO responder and its testbench.
//   - Region codes found in addr[31:28]
//   - MMIO register offsets inside the 0xF region (addr[27:0])
//   - FSM state encoding and the decoded access target
//   - decode_target(): maps a byte address to the target it selects
package mio_pkg;

    localparam logic [3:0]  REG_RAM  = 4'h0;
    localparam logic [3:0]  REG_MMIO = 4'hF;

    localparam logic [27:0] SW_OFF   = 28'h000_0000;
    localparam logic [27:0] LED_OFF  = 28'h000_0004;
    localparam logic [27:0] CNT_OFF  = 28'h000_0008;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        TGT_RAM,
        TGT_SW,
        TGT_LED,
        TGT_CNT,
        TGT_NONE
    } target_t;

    // Misaligned addresses and anything outside RAM or the three MMIO
    // registers land on TGT_NONE, which the responder treats as unmapped.
    function automatic target_t decode_target(input logic [31:0] a);
        target_t t;
        t = TGT_NONE;
        if (a[1:0] == 2'b00) begin
            if (a[31:28] == REG_RAM) begin
                t = TGT_RAM;
            end else if (a[31:28] == REG_MMIO) begin
                case (a[27:0])
                    SW_OFF:  t = TGT_SW;
                    LED_OFF: t = TGT_LED;
                    CNT_OFF: t = TGT_CNT;
                    default: t = TGT_NONE;
                endcase
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/mio_ram.sv
// mio_ram: single-port synchronous word RAM, read-first.
//   clk   - system clock
//   we    - write enable, writes wdata to mem[addr] on the rising edge
//   addr  - word index
//   wdata - write data
//   rdata - registered read data of mem[addr] from the previous edge
// Contents are deliberately not reset.
module mio_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mio_responder.sv
// mio_responder: memory/IO-side responder for the multi-cycle CPU bus.
// Serves MemRead/MemWrite requests from an internal RAM (RAM_LAT wait
// cycles) and a small MMIO block (switches, LEDs, cycle counter).
//   clk, reset        - clock, asynchronous active-high reset
//   mem_read/mem_write- level requests, held until mio_ready
//   addr, wdata       - byte address and write data, latched at accept
//   rdata             - read data, valid with mio_ready and held afterwards
//   mio_ready         - one-cycle completion pulse
//   bus_err           - sticky error flag (unmapped, misaligned, rd+wr)
//   sw_in             - raw switch inputs (two-flop synchronised)
//   led_out           - LED register
module mio_responder
    import mio_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int RAM_LAT = 2,
    parameter int LED_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             mio_ready,
    output logic             bus_err,
    input  logic [15:0]      sw_in,
    output logic [LED_W-1:0] led_out
);

    localparam logic [3:0] WAIT_INIT = 4'(RAM_LAT - 1);

    state_t            state;
    state_t            next_state;
    target_t           accept_tgt;
    target_t           lat_tgt;
    logic              req;
    logic              accept;
    logic [ADDR_W-1:0] lat_idx;
    logic [31:0]       lat_wdata;
    logic              lat_write;
    logic [3:0]        wait_cnt;
    logic [31:0]       ram_rdata;
    logic [31:0]       live_rdata;
    logic [31:0]       rdata_hold;
    logic [31:0]       cycle_cnt;
    logic [15:0]       sw_meta;
    logic [15:0]       sw_sync;
    logic [LED_W-1:0]  led_reg;
    logic              ram_we;
    logic              led_we;
    logic              cnt_clr;

    assign req        = mem_read | mem_write;
    assign accept_tgt = decode_target(addr);
    assign accept     = (state == IDLE) && req;
    assign led_out    = led_reg;

    // The RAM always reads the latched index; since every RAM access spends
    // at least one cycle in WAIT, its registered output is ready by RESP.
    mio_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (lat_idx),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A dropped request during WAIT abandons the access.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = (accept_tgt == TGT_RAM) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!req) begin
                    next_state = IDLE;
                end else if (wait_cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs and write strobes. All writes commit only in RESP; during a
    // read response the live value is forwarded so rdata is valid with
    // mio_ready, otherwise the last completed read is shown.
    always_comb begin
        mio_ready = 1'b0;
        ram_we    = 1'b0;
        led_we    = 1'b0;
        cnt_clr   = 1'b0;
        rdata     = rdata_hold;
        if (state == RESP) begin
            mio_ready = 1'b1;
            ram_we    = lat_write && (lat_tgt == TGT_RAM);
            led_we    = lat_write && (lat_tgt == TGT_LED);
            cnt_clr   = lat_write && (lat_tgt == TGT_CNT);
            if (!lat_write) begin
                rdata = live_rdata;
            end
        end
    end

    // Read source selection; unmapped targets read as zero.
    always_comb begin
        case (lat_tgt)
            TGT_RAM: live_rdata = ram_rdata;
            TGT_SW:  live_rdata = {16'h0000, sw_sync};
            TGT_LED: live_rdata = 32'(led_reg);
            TGT_CNT: live_rdata = cycle_cnt;
            default: live_rdata = 32'h0000_0000;
        endcase
    end

    // Request capture at accept and the RAM wait countdown. A simultaneous
    // read+write is captured as a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_idx   <= '0;
            lat_wdata <= 32'h0;
            lat_write <= 1'b0;
            lat_tgt   <= TGT_NONE;
            wait_cnt  <= 4'd0;
        end else if (accept) begin
            lat_idx   <= addr[ADDR_W+1:2];
            lat_wdata <= wdata;
            lat_write <= mem_write;
            lat_tgt   <= accept_tgt;
            wait_cnt  <= WAIT_INIT;
        end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Sticky error: raised when a faulty request is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if (accept && ((accept_tgt == TGT_NONE) || (mem_read && mem_write))) begin
            bus_err <= 1'b1;
        end
    end

    // Read data holding register, updated when a read response ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_hold <= 32'h0;
        end else if ((state == RESP) && !lat_write) begin
            rdata_hold <= live_rdata;
        end
    end

    // Switch synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= 16'h0;
            sw_sync <= 16'h0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    // LED register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_reg <= '0;
        end else if (led_we) begin
            led_reg <= lat_wdata[LED_W-1:0];
        end
    end

    // Free-running cycle counter; a CPU write wins over the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= 32'h0;
        end else if (cnt_clr) begin
            cycle_cnt <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mio_responder.sv
// tb_mio_responder: directed and randomized checks of mio_responder against
// a behavioural model (word array for RAM, LED/switch values, counter
// expressed as cycles elapsed since its last clear, sticky error flag).
module tb_mio_responder;

    localparam int ADDR_W   = 10;
    localparam int RAM_LAT  = 2;
    localparam int LED_W    = 8;
    localparam int RAM_RESP = RAM_LAT + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             mio_ready;
    logic             bus_err;
    logic [15:0]      sw_in;
    logic [LED_W-1:0] led_out;

    int total = 0;
    int bad   = 0;
    int tb_cycle = 0;
    int cnt_base = 0;
    int resp_cycle = 0;

    logic [31:0]      mem_m [16];
    logic [LED_W-1:0] led_m;
    logic [15:0]      sw_m;
    logic [31:0]      last_rd;
    bit               err_m;

    always #5 clk = ~clk;

    always @(posedge clk) tb_cycle++;

    mio_responder #(
        .ADDR_W  (ADDR_W),
        .RAM_LAT (RAM_LAT),
        .LED_W   (LED_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .mio_ready (mio_ready),
        .bus_err   (bus_err),
        .sw_in     (sw_in),
        .led_out   (led_out)
    );

    // Drives one request from an IDLE cycle, waits (bounded) for mio_ready,
    // and returns in the IDLE cycle that follows the response.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] got,
                             output int lat, output bit ok, output logic ready_after);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        lat = 0;
        ok  = 1'b0;
        got = 32'hxxxx_xxxx;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            lat++;
            if (mio_ready === 1'b1) begin
                ok  = 1'b1;
                got = rdata;
                resp_cycle = tb_cycle;
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        ready_after = mio_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; wdata = 32'h0; sw_in = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=%h", rdata, 32'h0); end
        total++; if (mio_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", mio_ready); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_bus_err got=%b want=0", bus_err); end
        total++; if (led_out !== '0) begin bad++; $display("[TB] FAIL reset_led got=%h want=0", led_out); end
        reset = 1'b0;
        cnt_base = tb_cycle;
        led_m = '0; sw_m = 16'h0; last_rd = 32'h0; err_m = 1'b0;
        // Counter reads as cycles since reset release.
        begin
            logic [31:0] got; int lat; bit ok; logic ra; logic [31:0] exp;
            do_access(1'b1, 1'b0, 32'hF000_0008, 32'h0, got, lat, ok, ra);
            exp = 32'(resp_cycle - cnt_base);
            total++; if (!ok || got !== exp) begin bad++; $display("[TB] FAIL reset_counter got=%h want=%h", got, exp); end
            last_rd = exp;
        end
    endtask

    task automatic test_ram_basic();
        logic [31:0] got; int lat; bit ok; logic ra;
        do_access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, got, lat, ok, ra);
        mem_m[4] = 32'hDEAD_BEEF;
        total++; if (!ok || lat != RAM_RESP) begin bad++; $display("[TB] FAIL ram_wr_latency got=%0d want=%0d", lat, RAM_RESP); end
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, got, lat, ok, ra);
        total++; if (!ok || lat != RAM_RESP) begin bad++; $display("[TB] FAIL ram_rd_latency got=%0d want=%0d", lat, RAM_RESP); end
        total++; if (got !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL ram_rd_data got=%h want=%h", got, 32'hDEAD_BEEF); end
        total++; if (ra !== 1'b0) begin bad++; $display("[TB] FAIL ram_ready_pulse got=%b want=0", ra); end
        total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL ram_rd_hold got=%h want=%h", rdata, 32'hDEAD_BEEF); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("[TB] FAIL ram_bus_err got=%b want=0", bus_err); end
        last_rd = 32'hDEAD_BEEF;
    endtask

    task automatic test_led();
        logic [31:0] got; int lat; bit ok; logic ra;
        do_access(1'b0, 1'b1, 32'hF000_0004, 32'h0000_00A5, got, lat, ok, ra);
        led_m = 8'hA5;
        total++; if (!ok || lat != 1) begin bad++; $display("[TB] FAIL led_wr_latency got=%0d want=1", lat); end
        total++; if (led_out !== 8'hA5) begin bad++; $display("[TB] FAIL led_out got=%h want=a5", led_out); end
        do_access(1'b1, 1'b0, 32'hF000_0004, 32'h0, got, lat, ok, ra);
        total++; if (!ok || got !== 32'h0000_00A5) begin bad++; $display("[TB] FAIL led_readback got=%h want=000000a5", got); end
        last_rd = 32'h0000_00A5;
    endtask

    task automatic test_switch();
        logic [31:0] got; int lat; bit ok; logic ra;
        sw_in = 16'h1234;
        sw_m  = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, 32'hF000_0000, 32'h0, got, lat, ok, ra);
        total++; if (!ok || lat != 1) begin bad++; $display("[TB] FAIL sw_latency got=%0d want=1", lat); end
        total++; if (got !== 32'h0000_1234) begin bad++; $display("[TB] FAIL sw_read got=%h want=00001234", got); end
        last_rd = 32'h0000_1234;
    endtask

    task automatic test_counter();
        logic [31:0] got; int lat; bit ok; logic ra; logic [31:0] exp; int gap;
        do_access(1'b0, 1'b1, 32'hF000_0008, $urandom, got, lat, ok, ra);
        cnt_base = resp_cycle + 1;
        do_access(1'b1, 1'b0, 32'hF000_0008, 32'h0, got, lat, ok, ra);
        exp = 32'(resp_cycle - cnt_base);
        total++; if (!ok || got !== exp) begin bad++; $display("[TB] FAIL cnt_after_clear got=%h want=%h", got, exp); end
        gap = $urandom_range(1, 6);
        repeat (gap) @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, 32'hF000_0008, 32'h0, got, lat, ok, ra);
        exp = 32'(resp_cycle - cnt_base);
        total++; if (!ok || got !== exp) begin bad++; $display("[TB] FAIL cnt_running got=%h want=%h", got, exp); end
        last_rd = exp;
    endtask

    task automatic test_abort();
        logic [31:0] got; int lat; bit ok; logic ra; bit seen;
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'h0000_FFFF, got, lat, ok, ra);
        mem_m[8] = 32'h0000_FFFF;
        mem_write = 1'b1; addr = 32'h0000_0020; wdata = 32'h0000_1111;
        @(posedge clk); #1;
        mem_write = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            if (mio_ready !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen) begin bad++; $display("[TB] FAIL abort_no_ready got=1 want=0"); end
        do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, got, lat, ok, ra);
        total++; if (!ok || lat != RAM_RESP) begin bad++; $display("[TB] FAIL abort_idle_latency got=%0d want=%0d", lat, RAM_RESP); end
        total++; if (got !== 32'h0000_FFFF) begin bad++; $display("[TB] FAIL abort_data got=%h want=0000ffff", got); end
        last_rd = 32'h0000_FFFF;
    endtask

    task automatic test_unmapped();
        logic [31:0] got; int lat; bit ok; logic ra;
        do_access(1'b1, 1'b0, 32'h8000_0000, 32'h0, got, lat, ok, ra);
        err_m = 1'b1;
        last_rd = 32'h0;
        total++; if (!ok || lat != 1) begin bad++; $display("[TB] FAIL unm_latency got=%0d want=1", lat); end
        total++; if (got !== 32'h0) begin bad++; $display("[TB] FAIL unm_rdata got=%h want=0", got); end
        total++; if (bus_err !== 1'b1) begin bad++; $display("[TB] FAIL unm_bus_err got=%b want=1", bus_err); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus_err !== 1'b1) begin bad++; $display("[TB] FAIL unm_sticky got=%b want=1", bus_err); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] got; int lat; bit ok; logic ra; bit seen;
        do_access(1'b0, 1'b1, 32'h0000_0030, 32'h0000_AAAA, got, lat, ok, ra);
        mem_m[12] = 32'h0000_AAAA;
        mem_write = 1'b1; addr = 32'h0000_0030; wdata = 32'h0000_5555;
        @(posedge clk); #1;
        reset = 1'b1;
        mem_write = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            #1;
            if (mio_ready !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen) begin bad++; $display("[TB] FAIL rst_wait_ready got=1 want=0"); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_wait_bus_err got=%b want=0", bus_err); end
        reset = 1'b0;
        cnt_base = tb_cycle;
        led_m = '0; err_m = 1'b0; last_rd = 32'h0;
        do_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, got, lat, ok, ra);
        total++; if (!ok || lat != RAM_RESP) begin bad++; $display("[TB] FAIL rst_wait_accept got=%0d want=%0d", lat, RAM_RESP); end
        total++; if (got !== 32'h0000_AAAA) begin bad++; $display("[TB] FAIL rst_wait_no_write got=%h want=0000aaaa", got); end
        last_rd = 32'h0000_AAAA;
    endtask

    task automatic test_random(input int n, input bit allow_err);
        logic [31:0] got; int lat; bit ok; logic ra;
        if (!allow_err) begin
            for (int w = 0; w < 16; w++) begin
                logic [31:0] d;
                d = $urandom;
                do_access(1'b0, 1'b1, 32'(w) << 2, d, got, lat, ok, ra);
                mem_m[w] = d;
                total++; if (!ok || lat != RAM_RESP) begin bad++; $display("[TB] FAIL rnd_init_latency idx=%0d got=%0d want=%0d", w, lat, RAM_RESP); end
            end
        end
        for (int i = 0; i < n; i++) begin
            int kind; int dir; int exp_lat; bit rd; bit wr; bit unm;
            logic [31:0] a; logic [31:0] d; logic [31:0] exp;
            if ($urandom_range(0, 3) == 0) begin
                sw_in = 16'($urandom);
                sw_m  = sw_in;
                repeat (3) @(posedge clk);
                #1;
            end
            kind = $urandom_range(0, allow_err ? 6 : 3);
            d = $urandom;
            case (kind)
                0:       a = {4'h0, 16'($urandom), 10'($urandom_range(0, 15)), 2'b00};
                1:       a = 32'hF000_0004;
                2:       a = 32'hF000_0000;
                3:       a = 32'hF000_0008;
                4:       a = {4'($urandom_range(1, 14)), 28'($urandom)};
                5:       a = {4'h0, 26'($urandom), 2'($urandom_range(1, 3))};
                default: a = 32'hF000_0000 | (32'($urandom_range(3, 255)) << 2);
            endcase
            dir = $urandom_range(0, allow_err ? 2 : 1);
            if (kind == 2) dir = 0;
            rd = (dir != 1);
            wr = (dir != 0);
            unm = (kind >= 4);
            exp_lat = (kind == 0) ? RAM_RESP : 1;
            do_access(rd, wr, a, d, got, lat, ok, ra);
            if (wr) begin
                if (kind == 0) mem_m[a[5:2]] = d;
                else if (kind == 1) led_m = d[LED_W-1:0];
                else if (kind == 3) cnt_base = resp_cycle + 1;
                exp = last_rd;
            end else begin
                case (kind)
                    0:       exp = mem_m[a[5:2]];
                    1:       exp = 32'(led_m);
                    2:       exp = {16'h0, sw_m};
                    3:       exp = 32'(resp_cycle - cnt_base);
                    default: exp = 32'h0;
                endcase
                last_rd = exp;
            end
            if (unm || (rd && wr)) err_m = 1'b1;
            total++; if (!ok || lat != exp_lat) begin bad++; $display("[TB] FAIL rnd_latency i=%0d addr=%h got=%0d want=%0d", i, a, lat, exp_lat); end
            total++; if (got !== exp) begin bad++; $display("[TB] FAIL rnd_rdata i=%0d addr=%h rd=%b wr=%b got=%h want=%h", i, a, rd, wr, got, exp); end
            total++; if (ra !== 1'b0) begin bad++; $display("[TB] FAIL rnd_ready_pulse i=%0d got=%b want=0", i, ra); end
            total++; if (bus_err !== err_m) begin bad++; $display("[TB] FAIL rnd_bus_err i=%0d addr=%h got=%b want=%b", i, a, bus_err, err_m); end
            total++; if (led_out !== led_m) begin bad++; $display("[TB] FAIL rnd_led i=%0d got=%h want=%h", i, led_out, led_m); end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_ram_basic();
        test_led();
        test_switch();
        test_counter();
        test_abort();
        test_random(40, 1'b0);
        test_unmapped();
        test_reset_mid_wait();
        test_random(60, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
